// File: rtl/spi_bus_arbiter.sv
// Round-robin owner selection and single-word SPI sequencer for several on-chip requesters.
// Drives chip select, a mode-0 serial clock and MSB-first data, and captures the returned word.
module spi_bus_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_CLK_PERIOD = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in,
    output logic [NUM_REQ-1:0]              grant_out,
    output logic                            busy_out,
    output logic [NUM_REQ-1:0]              done_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            chip_sel_out,
    output logic                            chip_clk_out,
    output logic                            chip_data_out,
    input  logic                            chip_data_in
);

    localparam int HALF  = DATA_CLK_PERIOD / 2;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CYC_W = $clog2(DATA_CLK_PERIOD);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic                   busy_q, busy_d;
    logic                   sel_q, sel_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;

    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic                   hit_s;

    // Round-robin search: first requester at or after last_grant+1, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s      = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            hit_s       = !win_found_s && req_in[cand_s];
            win_idx_s   = hit_s ? cand_s : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    // Next-state and registered-output logic of the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        data_d       = data_q;
        grant_d      = grant_q;
        done_d       = '0;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        sel_d        = sel_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d          = ST_SHIFT;
                    grant_d          = '0;
                    grant_d[win_idx_s] = 1'b1;
                    owner_d          = win_idx_s;
                    tx_d             = data_in[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                    mosi_d           = tx_d[DATA_WIDTH-1];
                    rx_d             = '0;
                    sel_d            = 1'b0;
                    busy_d           = 1'b1;
                    cyc_d            = '0;
                    bit_d            = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(HALF - 1)) begin
                    sclk_d   = 1'b1;
                    rx_d     = rx_q << 1;
                    rx_d[0]  = chip_data_in;
                end else if (cyc_q == CYC_W'(DATA_CLK_PERIOD - 1)) begin
                    sclk_d = 1'b0;
                    cyc_d  = '0;
                    // Last falling edge closes the frame together with chip select.
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d         = ST_DONE;
                        sel_d           = 1'b1;
                        data_d          = rx_q;
                        done_d[owner_q] = 1'b1;
                        grant_d         = '0;
                        busy_d          = 1'b0;
                        last_grant_d    = owner_q;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = tx_q << 1;
                        mosi_d = tx_d[DATA_WIDTH-1];
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            bit_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            data_q       <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            busy_q       <= 1'b0;
            sel_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            data_q       <= data_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            sel_q        <= sel_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
        end
    end

    assign grant_out     = grant_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign data_out      = data_q;
    assign chip_sel_out  = sel_q;
    assign chip_clk_out  = sclk_q;
    assign chip_data_out = mosi_q;

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one SPI bus (sel / data_clk / data lines) among NUM_REQ on-chip requesters.
- Grants the bus to one requester, generates chip select and serial clock, shifts its word out MSB-first, and captures the returned serial word.
- Sits between the application logic and the SPI pins. It drives the same signal set that spi_rx consumes (sel low-active, data_clk, serial data).

Parameters:
- NUM_REQ, 2, number of requesters; must be ≥1.
- DATA_WIDTH, 8, bits per transaction in each direction.
- DATA_CLK_PERIOD, 4, clk_in cycles per data_clk period; must be even and ≥2; HALF = DATA_CLK_PERIOD/2.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- req_in  input  NUM_REQ  level request per requester; held until its done pulse.
- data_in  input  NUM_REQ*DATA_WIDTH  transmit words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant_out  output  NUM_REQ  one-hot owner of current transaction; all zero when idle.
- busy_out  output  1  high while a transaction is in progress.
- done_out  output  NUM_REQ  one-cycle completion pulse to the owner.
- data_out  output  DATA_WIDTH  last received word; valid from the done cycle onward.
- chip_sel_out  output  1  chip select, active low.
- chip_clk_out  output  1  serial clock; idles low (mode 0).
- chip_data_out  output  1  serial data to device.
- chip_data_in  input  1  serial data from device.

Behaviour:
- Reset (async, immediate):
  - chip_sel_out=1, chip_clk_out=0, chip_data_out=0, busy_out=0.
  - grant_out=0, done_out=0, data_out=0.
  - Round-robin pointer set so requester 0 has highest priority.
  - FSM goes to IDLE. Any in-flight transaction is abandoned.
- IDLE:
  - On an edge where req_in≠0, pick the winner: the first set bit searching upward, with wrap, from (last_grant+1) mod NUM_REQ.
  - Latch the winner's data_in word.
  - Register grant_out=onehot(winner), busy_out=1, chip_sel_out=0, chip_data_out=word MSB.
  - Go to SHIFT.
- SHIFT:
  - Cycle counter 0..DATA_CLK_PERIOD-1 and bit counter 0..DATA_WIDTH-1.
  - Each bit occupies DATA_CLK_PERIOD cycles: chip_clk_out low for HALF cycles, then high for HALF cycles.
  - Rising data_clk (edge that makes chip_clk_out=1): chip_data_in is sampled into the receive shift register, MSB first.
  - Falling data_clk at end of bit:
    - If bits remain: chip_data_out is updated to the next bit.
    - After the last bit: chip_clk_out=0, chip_sel_out=1, data_out=received word, done_out[winner]=1, grant_out=0, busy_out=0, last_grant=winner; go to DONE.
  - chip_sel_out is low for exactly DATA_WIDTH*DATA_CLK_PERIOD cycles.
  - chip_data_out is stable HALF cycles before every rising data_clk.
- DONE: lasts one cycle (done_out high); then done_out=0 and go to IDLE.
  - chip_sel_out is high for at least 2 cycles between transactions.
  - Back-to-back latency: request observed in IDLE → chip_sel_out low on the next cycle.
- Requests:
  - req_in and data_in are sampled only in IDLE.
  - req_in deasserting mid-transaction is ignored; the transaction completes and done pulses.
  - A requester still holding req_in after its done re-enters arbitration with lowest priority.
- done_out and grant_out are never asserted for a requester other than the winner. At most one bit of each is high.
- data_out holds its value until the next done.
- NUM_REQ=1 degenerates to a simple sequencer (pointer unused).

Test Plan:
- Single transaction (NUM_REQ=2, DATA_WIDTH=8, PERIOD=4):
  - Stimulus: req_in=01, data word0=0xA5; device model returns 0x3C on chip_data_in, changing on falling data_clk.
  - Required: chip_sel_out low exactly 32 cycles; 8 data_clk pulses, each 2 high / 2 low; MOSI bits 1,0,1,0,0,1,0,1; done_out=01 for 1 cycle as sel rises; data_out=0x3C.
- Contention:
  - Stimulus: req_in=11 from reset, held; word0=0x11, word1=0x22.
  - Required: grants alternate 01,10,01,10; MOSI words alternate 0x11, 0x22; sel high ≥2 cycles between transactions.
- Request drop:
  - Stimulus: requester 1 drops req_in after bit 3 of its transaction.
  - Required: all 8 bits still clocked; done_out=10 pulses once; next grant only to an active requester.
- Reset mid-transfer:
  - Stimulus: assert rst_in asynchronously at bit 4.
  - Required: sel=1, clk=0, grant=0, busy=0 immediately (no clock edge needed); after release with req_in=10, requester 1 is granted and the full 8-bit transfer restarts.
- Minimum period:
  - Stimulus: PERIOD=2, DATA_WIDTH=16, loopback MOSI→MISO, word=0xBEEF.
  - Required: sel low 32 cycles; data_out=0xBEEF.
- Idle quiet:
  - Stimulus: req_in=0 for 100 cycles.
  - Required: sel=1, clk=0, grant=0, done=0 throughout.
